branch_resolve_unit: RTL
========================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- XLEN, 32, datapath width; legal values 32 or 64.
- RAS_DEPTH, 4, return-address-stack entries; power of two, or 0 to remove the stack.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- flush, in, 1, discard the in-flight result.
- in_valid, in, 1, request valid.
- in_ready, out, 1, unit can accept a request.
- in_pc, in, XLEN, PC of the branch.
- in_op, in, 6, instruction number; 32..42 are the branch ops.
- in_imm, in, XLEN, sign-extended imm16.
- in_addr26, in, 26, jump field.
- in_rs, in, XLEN, rs operand.
- in_rt, in, XLEN, rt operand.
- in_pred_pc, in, XLEN, front-end predicted next PC.
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts the result.
- out_pc, out, XLEN, resolved next PC.
- out_link, out, XLEN, in_pc+4.
- out_link_we, out, 1, link register write enable.
- out_taken, out, 1, branch or jump taken.
- out_mispredict, out, 1, out_pc differs from in_pred_pc.
- ras_top, out, XLEN, predicted return address.
- ras_valid, out, 1, stack non-empty.
REQ-003 Reset is synchronous and active-high on signal reset; clock is clk; all state updates on the rising edge.

Function
REQ-004 Handshake: in_ready = !flush && (!out_valid || out_ready); a request is accepted when in_valid && in_ready.
REQ-005 Latency: an accepted request produces registered outputs with out_valid=1 on the next edge; outputs hold stable while out_valid && !out_ready.
REQ-006 Branch conditions, rs taken as signed:
- 32 BEQ: rs==rt.
- 33 BGEZ: rs>=0.
- 34 BGTZ: rs>0.
- 35 BLEZ: rs<=0.
- 36 BLTZ: rs<0.
- 37 BGEZAL: rs>=0.
- 38 BLTZAL: rs<0.
REQ-007 For ops 32..38: taken target = in_pc + (in_imm<<2), modulo 2^XLEN; not-taken target = in_pc+4.
REQ-008 Ops 39 J and 40 JAL: out_pc = {in_pc[XLEN-1:28], in_addr26, in_pc[1:0]}; out_taken=1.
REQ-009 Ops 41 JR and 42 JALR: out_pc = in_rs; out_taken=1.
REQ-010 out_link_we=1 for ops 37, 38, 40 and 42, regardless of the condition; otherwise 0.
REQ-011 Any other op: out_pc = in_pc+4, out_taken=0, out_link_we=0, no stack effect.
REQ-012 out_mispredict = (out_pc != in_pred_pc), registered together with the other outputs.
REQ-013 RAS push on an accepted op 37, 38, 40 or 42: value in_pc+4.
REQ-014 RAS pop on an accepted op 41 when non-empty; a pop when empty is a no-op.
REQ-015 RAS full-stack push overwrites the oldest entry (circular pointer wrap); the entry count saturates at RAS_DEPTH.
REQ-016 ras_top and ras_valid are combinational from stack state; with RAS_DEPTH=0 both are tied to 0.
REQ-017 flush: out_valid clears on the next edge; no acceptance occurs in a flush cycle; stack contents are not rolled back.
REQ-018 flush together with out_ready in the same cycle: the result is treated as consumed, then cleared.

Reset
REQ-019 On reset: out_valid=0, out_pc=0, out_link=0, out_link_we=0, out_taken=0, out_mispredict=0; RAS count and pointer =0, so ras_valid=0.
REQ-020 Reset mid-transfer discards the pending result; reset has priority over flush and acceptance.

Structure
REQ-021 A shared package holds the op-number constants (32..42) and the link-op and condition-op classification functions.
REQ-022 The return-address stack is one sub-module, ras_stack (push, pop, top, valid, RAS_DEPTH parameter).

Verification
REQ-023 BEQ, pc=0x100, rs=rt=5, imm=4, pred=0x104 -> out_pc=0x110, taken=1, mispredict=1.
REQ-024 BLTZAL, pc=0x200, rs=0x80000000, imm=-2 -> out_pc=0x1F8, link=0x204, link_we=1, ras_top=0x204.
REQ-025 Five JALs with RAS_DEPTH=4, then four JRs -> pops return the four newest link values in reverse order; ras_valid=0 afterwards.
REQ-026 out_ready held 0 for 3 cycles -> in_ready=0 and outputs stable; release -> next request accepted in the same cycle.
REQ-027 flush asserted with out_valid=1 -> out_valid=0 next cycle; in_valid during the flush cycle is not accepted.
REQ-028 XLEN=64, JR rs=0xFFFF_0000_0000_1000 -> out_pc equals rs exactly; op 0 -> out_pc=pc+4, taken=0.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - op numbers and op classification shared by the branch resolve unit
package branch_resolve_unit_pkg;

   localparam logic [5:0] OP_BEQ    = 6'd32;
   localparam logic [5:0] OP_BGEZ   = 6'd33;
   localparam logic [5:0] OP_BGTZ   = 6'd34;
   localparam logic [5:0] OP_BLEZ   = 6'd35;
   localparam logic [5:0] OP_BLTZ   = 6'd36;
   localparam logic [5:0] OP_BGEZAL = 6'd37;
   localparam logic [5:0] OP_BLTZAL = 6'd38;
   localparam logic [5:0] OP_J      = 6'd39;
   localparam logic [5:0] OP_JAL    = 6'd40;
   localparam logic [5:0] OP_JR     = 6'd41;
   localparam logic [5:0] OP_JALR   = 6'd42;

   typedef enum logic [1:0] {
      TGT_SEQ,
      TGT_BRANCH,
      TGT_JUMP,
      TGT_REG
   } target_sel_e;

   function automatic logic is_link_op(input logic [5:0] op);
      return (op == OP_BGEZAL) || (op == OP_BLTZAL) || (op == OP_JAL) || (op == OP_JALR);
   endfunction

   function automatic logic is_cond_op(input logic [5:0] op);
      return (op >= OP_BEQ) && (op <= OP_BLTZAL);
   endfunction

   // A not-taken conditional branch resolves to the sequential target, so taken == (sel != TGT_SEQ).
   function automatic target_sel_e target_sel(input logic [5:0] op, input logic cond_true);
      target_sel_e sel;
      sel = TGT_SEQ;
      if (is_cond_op(op)) begin
         sel = cond_true ? TGT_BRANCH : TGT_SEQ;
      end else if ((op == OP_J) || (op == OP_JAL)) begin
         sel = TGT_JUMP;
      end else if ((op == OP_JR) || (op == OP_JALR)) begin
         sel = TGT_REG;
      end
      return sel;
   endfunction

endpackage

// File: rtl/branch_resolve_unit_ras_stack.sv
// rtl/branch_resolve_unit_ras_stack.sv - circular return-address stack
// A push on a full stack overwrites the oldest entry; the count saturates at RAS_DEPTH.
module ras_stack #(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] push_data,
   output logic [XLEN-1:0] top,
   output logic            valid
);

   generate
      if (RAS_DEPTH == 0) begin : g_none
         assign top   = '0;
         assign valid = 1'b0;
      end else begin : g_stack
         localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
         localparam int CW = $clog2(RAS_DEPTH + 1);

         logic [XLEN-1:0] mem [RAS_DEPTH];
         logic [PW-1:0]   ptr;
         logic [PW-1:0]   top_idx;
         logic [PW-1:0]   next_ptr;
         logic [CW-1:0]   count;

         // ptr is the next write slot; the newest entry sits one below it, wrapping.
         assign top_idx  = (ptr == '0) ? PW'(RAS_DEPTH - 1) : ptr - 1'b1;
         assign next_ptr = (ptr == PW'(RAS_DEPTH - 1)) ? '0 : ptr + 1'b1;
         assign valid    = (count != '0);
         assign top      = valid ? mem[top_idx] : '0;

         always_ff @(posedge clk) begin
            if (reset) begin
               ptr   <= '0;
               count <= '0;
            end else if (push) begin
               ptr <= next_ptr;
               if (count != CW'(RAS_DEPTH)) begin
                  count <= count + 1'b1;
               end
            end else if (pop && valid) begin
               ptr   <= top_idx;
               count <= count - 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (!reset && push) begin
               mem[ptr] <= push_data;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - resolves branch/jump next PC with a one-entry output register and RAS
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [5:0]      in_op,
   input  logic [XLEN-1:0] in_imm,
   input  logic [25:0]     in_addr26,
   input  logic [XLEN-1:0] in_rs,
   input  logic [XLEN-1:0] in_rt,
   input  logic [XLEN-1:0] in_pred_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_link,
   output logic            out_link_we,
   output logic            out_taken,
   output logic            out_mispredict,
   output logic [XLEN-1:0] ras_top,
   output logic            ras_valid
);

   logic            accept;
   logic            rs_neg;
   logic            rs_zero;
   logic            cond_true;
   target_sel_e     sel;
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] branch_pc;
   logic [XLEN-1:0] jump_pc;
   logic [XLEN-1:0] next_pc;

   assign in_ready = !flush && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   assign rs_neg    = in_rs[XLEN-1];
   assign rs_zero   = (in_rs == '0);
   assign seq_pc    = in_pc + XLEN'(4);
   assign branch_pc = in_pc + (in_imm << 2);
   assign jump_pc   = {in_pc[XLEN-1:28], in_addr26, in_pc[1:0]};

   always_comb begin
      cond_true = 1'b0;
      case (in_op)
         OP_BEQ:    cond_true = (in_rs == in_rt);
         OP_BGEZ:   cond_true = !rs_neg;
         OP_BGTZ:   cond_true = !rs_neg && !rs_zero;
         OP_BLEZ:   cond_true = rs_neg || rs_zero;
         OP_BLTZ:   cond_true = rs_neg;
         OP_BGEZAL: cond_true = !rs_neg;
         OP_BLTZAL: cond_true = rs_neg;
         default:   cond_true = 1'b0;
      endcase
   end

   assign sel = target_sel(in_op, cond_true);

   always_comb begin
      next_pc = seq_pc;
      case (sel)
         TGT_BRANCH: next_pc = branch_pc;
         TGT_JUMP:   next_pc = jump_pc;
         TGT_REG:    next_pc = in_rs;
         default:    next_pc = seq_pc;
      endcase
   end

   // Flush wins over consumption; in_ready is already low during a flush so nothing is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid      <= 1'b0;
         out_pc         <= '0;
         out_link       <= '0;
         out_link_we    <= 1'b0;
         out_taken      <= 1'b0;
         out_mispredict <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid      <= 1'b1;
         out_pc         <= next_pc;
         out_link       <= seq_pc;
         out_link_we    <= is_link_op(in_op);
         out_taken      <= (sel != TGT_SEQ);
         out_mispredict <= (next_pc != in_pred_pc);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   ras_stack #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (accept && is_link_op(in_op)),
      .pop       (accept && (in_op == OP_JR)),
      .push_data (seq_pc),
      .top       (ras_top),
      .valid     (ras_valid)
   );

endmodule
